// File: rtl/v_pipe_update_ctl.sv
// Command scheduler for the table update pipeline: init sweep, three-stage
// read / compare / write-back sequencing and same-context hazard stalling.
module v_pipe_update_ctl #(
    parameter int CONTEXT_N = 8,
    parameter int ENTRIES_N = 16,
    parameter int KEY_W     = 32,
    localparam int CTX_W    = $clog2(CONTEXT_N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_cmd_vld,
    input  logic [1:0]           i_cmd_op,
    input  logic [CTX_W-1:0]     i_cmd_ctxt,
    input  logic [KEY_W-1:0]     i_cmd_key,
    output logic                 o_cmd_rdy,
    output logic                 o_st_rd_en,
    output logic [CTX_W-1:0]     o_st_rd_ctxt,
    output logic [KEY_W-1:0]     o_cmp_key,
    input  logic                 i_match_hit,
    input  logic                 i_match_full,
    input  logic [ENTRIES_N-1:0] i_match_sel,
    input  logic [ENTRIES_N-1:0] i_mask_cmp,
    output logic                 o_st_wr_en,
    output logic [1:0]           o_st_wr_op,
    output logic [CTX_W-1:0]     o_st_wr_ctxt,
    output logic [KEY_W-1:0]     o_st_wr_key,
    output logic [ENTRIES_N-1:0] o_st_wr_sel,
    output logic [ENTRIES_N-1:0] o_st_wr_mask,
    output logic                 o_rsp_vld,
    output logic [CTX_W-1:0]     o_rsp_ctxt,
    output logic [1:0]           o_rsp_status,
    output logic                 o_init_done,
    output logic                 o_busy
);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [1:0] OP_CLR = 2'd0;
    localparam logic [1:0] OP_ADD = 2'd1;
    localparam logic [1:0] OP_DEL = 2'd2;
    localparam logic [1:0] OP_QRY = 2'd3;

    localparam logic [1:0] WR_CLEAR  = 2'd0;
    localparam logic [1:0] WR_INSERT = 2'd1;
    localparam logic [1:0] WR_UPDATE = 2'd2;
    localparam logic [1:0] WR_REMOVE = 2'd3;

    localparam logic [1:0] RSP_OK       = 2'd0;
    localparam logic [1:0] RSP_FULL     = 2'd1;
    localparam logic [1:0] RSP_NOTFOUND = 2'd2;

    localparam logic [CTX_W-1:0] LAST_CTXT = CTX_W'(CONTEXT_N - 1);

    logic [0:0]           state_r;
    logic [CTX_W-1:0]     init_cnt_r;

    logic                 s1_vld_r;
    logic [1:0]           s1_op_r;
    logic [CTX_W-1:0]     s1_ctxt_r;
    logic [KEY_W-1:0]     s1_key_r;

    logic                 s2_vld_r;
    logic [1:0]           s2_op_r;
    logic [CTX_W-1:0]     s2_ctxt_r;
    logic [KEY_W-1:0]     s2_key_r;

    logic                 s3_vld_r;
    logic                 s3_wr_en_r;
    logic [1:0]           s3_wr_op_r;
    logic [CTX_W-1:0]     s3_ctxt_r;
    logic [KEY_W-1:0]     s3_key_r;
    logic [ENTRIES_N-1:0] s3_sel_r;
    logic [ENTRIES_N-1:0] s3_mask_r;
    logic [1:0]           s3_status_r;

    logic                 hzd_s1_s;
    logic                 hzd_s2_s;
    logic                 hzd_s3_s;
    logic                 cmd_rdy_s;
    logic                 accept_s;

    logic                 dec_wr_en_s;
    logic [1:0]           dec_wr_op_s;
    logic [1:0]           dec_status_s;

    // A new command stalls while its context is still anywhere in S1..S3
    assign hzd_s1_s  = s1_vld_r & (s1_ctxt_r == i_cmd_ctxt);
    assign hzd_s2_s  = s2_vld_r & (s2_ctxt_r == i_cmd_ctxt);
    assign hzd_s3_s  = s3_vld_r & (s3_ctxt_r == i_cmd_ctxt);
    assign cmd_rdy_s = ~rst & (state_r == ST_RUN)
                     & ~(i_cmd_vld & (hzd_s1_s | hzd_s2_s | hzd_s3_s));
    assign accept_s  = i_cmd_vld & cmd_rdy_s;

    // Init sweep counter and INIT/RUN sequencing
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_INIT;
            init_cnt_r <= {CTX_W{1'b0}};
        end else begin
            case (state_r)
                ST_INIT: begin
                    if (init_cnt_r == LAST_CTXT) begin
                        state_r    <= ST_RUN;
                        init_cnt_r <= {CTX_W{1'b0}};
                    end else begin
                        init_cnt_r <= init_cnt_r + CTX_W'(1);
                    end
                end
                ST_RUN: begin
                    state_r <= ST_RUN;
                end
                default: begin
                    state_r    <= ST_INIT;
                    init_cnt_r <= {CTX_W{1'b0}};
                end
            endcase
        end
    end

    // S1 and S2 carry the command forward one stage per cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_r  <= 1'b0;
            s1_op_r   <= 2'd0;
            s1_ctxt_r <= {CTX_W{1'b0}};
            s1_key_r  <= {KEY_W{1'b0}};
            s2_vld_r  <= 1'b0;
            s2_op_r   <= 2'd0;
            s2_ctxt_r <= {CTX_W{1'b0}};
            s2_key_r  <= {KEY_W{1'b0}};
        end else begin
            s1_vld_r <= accept_s;
            if (accept_s) begin
                s1_op_r   <= i_cmd_op;
                s1_ctxt_r <= i_cmd_ctxt;
                s1_key_r  <= i_cmd_key;
            end
            s2_vld_r <= s1_vld_r;
            if (s1_vld_r) begin
                s2_op_r   <= s1_op_r;
                s2_ctxt_r <= s1_ctxt_r;
                s2_key_r  <= s1_key_r;
            end
        end
    end

    // Turn the compare result for the S2 command into a write-back and status
    always_comb begin
        dec_wr_en_s  = 1'b0;
        dec_wr_op_s  = WR_CLEAR;
        dec_status_s = RSP_OK;
        case (s2_op_r)
            OP_CLR: begin
                dec_wr_en_s = 1'b1;
                dec_wr_op_s = WR_CLEAR;
            end
            OP_ADD: begin
                if (i_match_hit) begin
                    dec_wr_en_s = 1'b1;
                    dec_wr_op_s = WR_UPDATE;
                end else if (i_match_full) begin
                    dec_status_s = RSP_FULL;
                end else begin
                    dec_wr_en_s = 1'b1;
                    dec_wr_op_s = WR_INSERT;
                end
            end
            OP_DEL: begin
                if (i_match_hit) begin
                    dec_wr_en_s = 1'b1;
                    dec_wr_op_s = WR_REMOVE;
                end else begin
                    dec_status_s = RSP_NOTFOUND;
                end
            end
            OP_QRY: begin
                if (i_match_hit) begin
                    dec_status_s = RSP_OK;
                end else begin
                    dec_status_s = RSP_NOTFOUND;
                end
            end
            default: begin
                dec_wr_en_s  = 1'b0;
                dec_status_s = RSP_OK;
            end
        endcase
    end

    // S3 holds the decoded write-back and response for one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            s3_vld_r    <= 1'b0;
            s3_wr_en_r  <= 1'b0;
            s3_wr_op_r  <= 2'd0;
            s3_ctxt_r   <= {CTX_W{1'b0}};
            s3_key_r    <= {KEY_W{1'b0}};
            s3_sel_r    <= {ENTRIES_N{1'b0}};
            s3_mask_r   <= {ENTRIES_N{1'b0}};
            s3_status_r <= 2'd0;
        end else begin
            s3_vld_r   <= s2_vld_r;
            s3_wr_en_r <= s2_vld_r & dec_wr_en_s;
            if (s2_vld_r) begin
                s3_wr_op_r  <= dec_wr_op_s;
                s3_ctxt_r   <= s2_ctxt_r;
                s3_key_r    <= s2_key_r;
                s3_sel_r    <= i_match_sel;
                s3_mask_r   <= i_mask_cmp;
                s3_status_r <= dec_status_s;
            end
        end
    end

    // Output mux; reset forces every strobe and bus low in the same cycle
    always_comb begin
        o_cmd_rdy    = 1'b0;
        o_st_rd_en   = 1'b0;
        o_st_rd_ctxt = {CTX_W{1'b0}};
        o_cmp_key    = {KEY_W{1'b0}};
        o_st_wr_en   = 1'b0;
        o_st_wr_op   = WR_CLEAR;
        o_st_wr_ctxt = {CTX_W{1'b0}};
        o_st_wr_key  = {KEY_W{1'b0}};
        o_st_wr_sel  = {ENTRIES_N{1'b0}};
        o_st_wr_mask = {ENTRIES_N{1'b0}};
        o_rsp_vld    = 1'b0;
        o_rsp_ctxt   = {CTX_W{1'b0}};
        o_rsp_status = RSP_OK;
        o_init_done  = 1'b0;
        o_busy       = 1'b0;
        if (rst) begin
            o_busy = 1'b0;
        end else begin
            o_cmd_rdy    = cmd_rdy_s;
            o_st_rd_en   = s1_vld_r;
            o_st_rd_ctxt = s1_ctxt_r;
            o_cmp_key    = s2_key_r;
            if (state_r == ST_INIT) begin
                o_st_wr_en   = 1'b1;
                o_st_wr_op   = WR_CLEAR;
                o_st_wr_ctxt = init_cnt_r;
            end else begin
                o_st_wr_en   = s3_wr_en_r;
                o_st_wr_op   = s3_wr_op_r;
                o_st_wr_ctxt = s3_ctxt_r;
                o_st_wr_key  = s3_key_r;
                o_st_wr_sel  = s3_sel_r;
                o_st_wr_mask = s3_mask_r;
            end
            o_rsp_vld    = s3_vld_r;
            o_rsp_ctxt   = s3_ctxt_r;
            o_rsp_status = s3_status_r;
            o_init_done  = (state_r == ST_RUN);
            o_busy       = (state_r == ST_INIT) | s1_vld_r | s2_vld_r | s3_vld_r;
        end
    end

endmodule

// File: tb/tb_v_pipe_update_ctl.sv
// Bench for v_pipe_update_ctl: decode vector table, hazard/reset sequences and
// randomized traffic checked cycle by cycle against an in-flight command model.
module tb_v_pipe_update_ctl;

    logic        clk;
    logic        rst;
    logic        i_cmd_vld;
    logic [1:0]  i_cmd_op;
    logic [2:0]  i_cmd_ctxt;
    logic [31:0] i_cmd_key;
    logic        o_cmd_rdy;
    logic        o_st_rd_en;
    logic [2:0]  o_st_rd_ctxt;
    logic [31:0] o_cmp_key;
    logic        i_match_hit;
    logic        i_match_full;
    logic [15:0] i_match_sel;
    logic [15:0] i_mask_cmp;
    logic        o_st_wr_en;
    logic [1:0]  o_st_wr_op;
    logic [2:0]  o_st_wr_ctxt;
    logic [31:0] o_st_wr_key;
    logic [15:0] o_st_wr_sel;
    logic [15:0] o_st_wr_mask;
    logic        o_rsp_vld;
    logic [2:0]  o_rsp_ctxt;
    logic [1:0]  o_rsp_status;
    logic        o_init_done;
    logic        o_busy;

    v_pipe_update_ctl #(.CONTEXT_N(8), .ENTRIES_N(16), .KEY_W(32)) dut (
        .clk(clk), .rst(rst),
        .i_cmd_vld(i_cmd_vld), .i_cmd_op(i_cmd_op), .i_cmd_ctxt(i_cmd_ctxt), .i_cmd_key(i_cmd_key),
        .o_cmd_rdy(o_cmd_rdy), .o_st_rd_en(o_st_rd_en), .o_st_rd_ctxt(o_st_rd_ctxt),
        .o_cmp_key(o_cmp_key), .i_match_hit(i_match_hit), .i_match_full(i_match_full),
        .i_match_sel(i_match_sel), .i_mask_cmp(i_mask_cmp),
        .o_st_wr_en(o_st_wr_en), .o_st_wr_op(o_st_wr_op), .o_st_wr_ctxt(o_st_wr_ctxt),
        .o_st_wr_key(o_st_wr_key), .o_st_wr_sel(o_st_wr_sel), .o_st_wr_mask(o_st_wr_mask),
        .o_rsp_vld(o_rsp_vld), .o_rsp_ctxt(o_rsp_ctxt), .o_rsp_status(o_rsp_status),
        .o_init_done(o_init_done), .o_busy(o_busy)
    );

    typedef struct {
        int          acc;
        logic [1:0]  op;
        logic [2:0]  ctxt;
        logic [31:0] key;
        logic        hit;
        logic        full;
        logic [15:0] sel;
        logic [15:0] mask;
    } cmd_t;

    typedef struct {
        logic [1:0]  op;
        logic [2:0]  ctxt;
        logic [31:0] key;
        logic        hit;
        logic        full;
        logic [15:0] sel;
        logic [15:0] mask;
        logic        exp_wr;
        logic [1:0]  exp_op;
        logic [1:0]  exp_st;
    } vec_t;

    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   run_k = 0;
    cmd_t q[$];
    vec_t vt[10];
    logic [2:0] seq_ctxt[8];
    int   acc_cyc[8];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Spec decode rules: write enable, write op and response status
    function automatic void dec(input logic [1:0] op, input logic h, input logic f,
                                output logic w, output logic [1:0] wop, output logic [1:0] st);
        w = 1'b0; wop = 2'd0; st = 2'd0;
        if (op == 2'd0) begin w = 1'b1; wop = 2'd0; end
        else if (op == 2'd1) begin
            if (h) begin w = 1'b1; wop = 2'd2; end
            else if (f) st = 2'd1;
            else begin w = 1'b1; wop = 2'd1; end
        end else if (op == 2'd2) begin
            if (h) begin w = 1'b1; wop = 2'd3; end
            else st = 2'd2;
        end else begin
            st = h ? 2'd0 : 2'd2;
        end
    endfunction

    // Reference model step for one RUN cycle
    task automatic model_run();
        logic s1f, s3f, conflict, exp_rdy, w;
        logic [1:0] wop, st;
        cmd_t c1, c3;
        s1f = 1'b0; s3f = 1'b0; conflict = 1'b0;
        c1 = '{default: '0}; c3 = '{default: '0};
        for (int i = 0; i < q.size(); i++) begin
            if (cyc - q[i].acc == 1) begin s1f = 1'b1; c1 = q[i]; end
            if (cyc - q[i].acc == 2) begin
                chk("cmp_key", o_cmp_key, q[i].key);
                q[i].hit = i_match_hit; q[i].full = i_match_full;
                q[i].sel = i_match_sel; q[i].mask = i_mask_cmp;
            end
            if (cyc - q[i].acc == 3) begin s3f = 1'b1; c3 = q[i]; end
            if (q[i].ctxt == i_cmd_ctxt) conflict = 1'b1;
        end
        exp_rdy = !(i_cmd_vld && conflict);
        chk("cmd_rdy", o_cmd_rdy, exp_rdy);
        chk("init_done", o_init_done, 1'b1);
        chk("busy", o_busy, q.size() != 0);
        chk("rd_en", o_st_rd_en, s1f);
        if (s1f) chk("rd_ctxt", o_st_rd_ctxt, c1.ctxt);
        chk("rsp_vld", o_rsp_vld, s3f);
        if (s3f) begin
            dec(c3.op, c3.hit, c3.full, w, wop, st);
            chk("rsp_ctxt", o_rsp_ctxt, c3.ctxt);
            chk("rsp_status", o_rsp_status, st);
            chk("wr_en", o_st_wr_en, w);
            if (w) begin
                chk("wr_op", o_st_wr_op, wop);
                chk("wr_ctxt", o_st_wr_ctxt, c3.ctxt);
                chk("wr_key", o_st_wr_key, c3.key);
                if (c3.op != 2'd0) chk("wr_sel_mask", {o_st_wr_sel, o_st_wr_mask}, {c3.sel, c3.mask});
            end
        end else begin
            chk("wr_en_idle", o_st_wr_en, 1'b0);
        end
        while (q.size() > 0 && cyc - q[0].acc >= 3) void'(q.pop_front());
        if (i_cmd_vld && exp_rdy)
            q.push_back('{acc: cyc, op: i_cmd_op, ctxt: i_cmd_ctxt, key: i_cmd_key,
                          hit: 1'b0, full: 1'b0, sel: 16'd0, mask: 16'd0});
    endtask

    // Cycle-by-cycle monitor: reset, init sweep, then pipeline model
    initial forever begin
        @(negedge clk);
        if (rst) begin
            chk("rst_outs_zero",
                {o_cmd_rdy, o_st_rd_en, o_st_rd_ctxt, o_cmp_key, o_st_wr_en, o_st_wr_op,
                 o_st_wr_ctxt, o_st_wr_key, o_st_wr_sel, o_st_wr_mask, o_rsp_vld,
                 o_rsp_ctxt, o_rsp_status, o_init_done}, 128'd0);
            q.delete();
            run_k = 0;
        end else if (run_k < 8) begin
            chk("init_wr_en", o_st_wr_en, 1'b1);
            chk("init_wr_op", o_st_wr_op, 2'd0);
            chk("init_wr_ctxt", o_st_wr_ctxt, run_k);
            chk("init_wr_data", {o_st_wr_key, o_st_wr_sel, o_st_wr_mask}, 128'd0);
            chk("init_rdy", o_cmd_rdy, 1'b0);
            chk("init_rsp", o_rsp_vld, 1'b0);
            chk("init_done_lo", o_init_done, 1'b0);
            chk("init_busy", o_busy, 1'b1);
            run_k++;
        end else begin
            model_run();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in the first cycle after rst falls
    task automatic check_init();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("sweep_ctxt", {o_st_wr_en, o_st_wr_ctxt}, {1'b1, 3'(i)});
            tick();
        end
        @(negedge clk);
        chk("sweep_done_rdy", {o_init_done, o_cmd_rdy}, 2'b11);
        tick();
    endtask

    // Present seq_ctxt[0..n-1] as held-valid ADDs, recording accept cycles
    task automatic run_seq(input int n);
        int idx;
        int budget;
        idx = 0; budget = 0;
        i_cmd_vld = 1'b1; i_cmd_op = 2'd1; i_cmd_ctxt = seq_ctxt[0]; i_cmd_key = 32'hA000;
        while (idx < n && budget < 60) begin
            @(negedge clk);
            if (o_cmd_rdy) begin acc_cyc[idx] = cyc; idx++; end
            tick();
            budget++;
            if (idx < n) begin
                i_cmd_ctxt = seq_ctxt[idx]; i_cmd_key = 32'hA000 + 32'(idx);
            end else begin
                i_cmd_vld = 1'b0;
            end
        end
        chk("seq_all_accepted", idx, n);
        i_cmd_vld = 1'b0;
    endtask

    initial begin
        logic accepted;
        vt[0] = '{2'd1, 3'd2, 32'h10,       1'b0, 1'b0, 16'h0000, 16'h00F0, 1'b1, 2'd1, 2'd0};
        vt[1] = '{2'd1, 3'd3, 32'h11,       1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 2'd0, 2'd1};
        vt[2] = '{2'd2, 3'd3, 32'h12,       1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 2'd0, 2'd2};
        vt[3] = '{2'd2, 3'd4, 32'h13,       1'b1, 1'b0, 16'h0004, 16'h0004, 1'b1, 2'd3, 2'd0};
        vt[4] = '{2'd1, 3'd5, 32'h14,       1'b1, 1'b0, 16'h0100, 16'h0F00, 1'b1, 2'd2, 2'd0};
        vt[5] = '{2'd3, 3'd6, 32'h15,       1'b1, 1'b0, 16'h0001, 16'h0001, 1'b0, 2'd0, 2'd0};
        vt[6] = '{2'd3, 3'd7, 32'h16,       1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 2'd0, 2'd2};
        vt[7] = '{2'd0, 3'd0, 32'hDEADBEEF, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 2'd0, 2'd0};
        vt[8] = '{2'd1, 3'd1, 32'h18,       1'b1, 1'b1, 16'h8000, 16'h8001, 1'b1, 2'd2, 2'd0};
        vt[9] = '{2'd2, 3'd2, 32'h19,       1'b1, 1'b1, 16'h0040, 16'h00C0, 1'b1, 2'd3, 2'd0};

        rst = 1'b1; i_cmd_vld = 1'b0; i_cmd_op = 2'd0; i_cmd_ctxt = 3'd0; i_cmd_key = 32'd0;
        i_match_hit = 1'b0; i_match_full = 1'b0; i_match_sel = 16'd0; i_mask_cmp = 16'd0;
        repeat (3) tick();
        rst = 1'b0;
        check_init();

        // Decode table: one command every 4 cycles, match result driven at T+2
        for (int v = 0; v < 10; v++) begin
            i_cmd_vld = 1'b1; i_cmd_op = vt[v].op; i_cmd_ctxt = vt[v].ctxt; i_cmd_key = vt[v].key;
            @(negedge clk);
            chk("vec_rdy", o_cmd_rdy, 1'b1);
            tick();
            i_cmd_vld = 1'b0;
            @(negedge clk);
            chk("vec_rd", {o_st_rd_en, o_st_rd_ctxt}, {1'b1, vt[v].ctxt});
            tick();
            i_match_hit = vt[v].hit; i_match_full = vt[v].full;
            i_match_sel = vt[v].sel; i_mask_cmp = vt[v].mask;
            @(negedge clk);
            chk("vec_cmp_key", o_cmp_key, vt[v].key);
            tick();
            i_match_hit = 1'b0; i_match_full = 1'b0; i_match_sel = 16'd0; i_mask_cmp = 16'd0;
            @(negedge clk);
            chk("vec_rsp", {o_rsp_vld, o_rsp_ctxt, o_rsp_status}, {1'b1, vt[v].ctxt, vt[v].exp_st});
            chk("vec_wr_en", o_st_wr_en, vt[v].exp_wr);
            if (vt[v].exp_wr) begin
                chk("vec_wr_op", {o_st_wr_op, o_st_wr_ctxt}, {vt[v].exp_op, vt[v].ctxt});
                if (vt[v].op != 2'd0) chk("vec_wr_sel_mask", {o_st_wr_sel, o_st_wr_mask}, {vt[v].sel, vt[v].mask});
            end
            tick();
        end

        // Same-context stall: 1, 1, 5 held valid
        seq_ctxt[0] = 3'd1; seq_ctxt[1] = 3'd1; seq_ctxt[2] = 3'd5;
        run_seq(3);
        chk("haz_same_gap", acc_cyc[1] - acc_cyc[0], 4);
        chk("haz_next_gap", acc_cyc[2] - acc_cyc[1], 1);
        repeat (4) tick();

        // Distinct contexts back to back
        for (int i = 0; i < 8; i++) seq_ctxt[i] = 3'(i);
        run_seq(8);
        chk("b2b_span", acc_cyc[7] - acc_cyc[0], 7);
        repeat (4) tick();

        // Reset with S1..S3 all occupied
        seq_ctxt[0] = 3'd0; seq_ctxt[1] = 3'd1; seq_ctxt[2] = 3'd2;
        run_seq(3);
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("rst_mid_quiet", {o_rsp_vld, o_st_wr_en, o_st_rd_en}, 3'b000);
            tick();
        end
        rst = 1'b0;
        check_init();

        // Randomized traffic, stalled commands held, one mid-run reset
        i_cmd_vld = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            accepted = i_cmd_vld && o_cmd_rdy;
            tick();
            if (!i_cmd_vld || accepted) begin
                i_cmd_vld  = ($urandom_range(0, 3) != 0);
                i_cmd_op   = 2'($urandom_range(0, 3));
                i_cmd_ctxt = ($urandom_range(0, 1) != 0) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
                i_cmd_key  = $urandom;
            end
            i_match_hit  = 1'($urandom_range(0, 1));
            i_match_full = 1'($urandom_range(0, 1));
            i_match_sel  = 16'($urandom);
            i_mask_cmp   = 16'($urandom);
            rst = (c == 1500 || c == 1501);
        end
        i_cmd_vld = 1'b0;
        repeat (6) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
